// File: rtl/updown_counter_param_pkg.sv
// Shared constants and helpers for the parameterised up/down counter.
// Holds the boundary-mode encodings and the default terminal-count function.
package updown_counter_param_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widened to 64 bits so a 32-bit counter's all-ones value is representable.
    function automatic longint unsigned defaultMaxVal(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/updown_counter_param_cnt_next_calc.sv
// Combinational next-count and boundary-event detection for the up/down counter.
// All arithmetic is one bit wider than the count so carries and borrows are explicit.
module cnt_next_calc
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             boundary_o
);

    logic [WIDTH:0] countExt;
    logic [WIDTH:0] maxExt;
    logic [WIDTH:0] incr;
    logic [WIDTH:0] decr;

    assign countExt = {1'b0, count_i};
    assign maxExt   = {1'b0, max_val_i};
    assign incr     = countExt + {{WIDTH{1'b0}}, 1'b1};
    assign decr     = countExt - {{WIDTH{1'b0}}, 1'b1};

    // Counting past MAX_VAL shows up as incr > max; counting below zero as a borrow.
    always_comb begin
        next_count_o = count_i;
        boundary_o   = 1'b0;
        if (up_i) begin
            if (incr > maxExt) begin
                boundary_o   = 1'b1;
                next_count_o = (sat_i == MODE_SAT) ? max_val_i : '0;
            end else begin
                next_count_o = incr[WIDTH-1:0];
            end
        end else begin
            if (decr[WIDTH]) begin
                boundary_o   = 1'b1;
                next_count_o = (sat_i == MODE_SAT) ? '0 : max_val_i;
            end else begin
                next_count_o = decr[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with wrap/saturate boundaries, load, clear,
// a one-cycle boundary pulse and sticky overflow/underflow flags.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned       WIDTH   = 4,
    parameter longint unsigned   MAX_VAL = defaultMaxVal(WIDTH),
    parameter longint unsigned   RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    if (WIDTH < 2 || WIDTH > 32) begin : gBadWidth
        $error("updown_counter_param: WIDTH %0d outside 2..32", WIDTH);
    end
    if (MAX_VAL < 1 || MAX_VAL > defaultMaxVal(WIDTH)) begin : gBadMax
        $error("updown_counter_param: MAX_VAL %0d outside 1..2**WIDTH-1", MAX_VAL);
    end
    if (RST_VAL > MAX_VAL) begin : gBadRst
        $error("updown_counter_param: RST_VAL %0d exceeds MAX_VAL %0d", RST_VAL, MAX_VAL);
    end

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] nextCount;
    logic             boundary;

    cnt_next_calc #(
        .WIDTH(WIDTH)
    ) uNextCalc (
        .count_i     (count_q),
        .up_i        (up),
        .sat_i       (sat),
        .max_val_i   (MAX_W),
        .next_count_o(nextCount),
        .boundary_o  (boundary)
    );

    // Priority clr > load > en; tc is a pulse so it defaults low every cycle.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            count_d = RST_W;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (en) begin
            count_d = nextCount;
            tc_d    = boundary;
            if (boundary && up) begin
                ovf_d = 1'b1;
            end
            if (boundary && !up) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_W;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Testbench for updown_counter_param: one instance with MAX_VAL=9 and one with
// default parameters share stimulus and are checked against an integer model.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, sat, load, clr;
    logic [3:0] load_val;

    logic [3:0] countA, countB;
    logic       tcA, tcB, ovfA, ovfB, unfA, unfB;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    int maxv[2] = '{9, 15};
    int mCount[2];
    bit mTc[2], mOvf[2], mUnf[2];

    updown_counter_param #(
        .WIDTH  (4),
        .MAX_VAL(9),
        .RST_VAL(0)
    ) dutA (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr(clr),
        .count(countA), .tc(tcA), .ovf(ovfA), .unf(unfA)
    );

    updown_counter_param dutB (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .clr(clr),
        .count(countB), .tc(tcB), .ovf(ovfB), .unf(unfB)
    );

    always #5 clk = ~clk;

    // Reference behaviour: plain integer counting with clamp/wrap at the bounds.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mCount[k] = 0; mTc[k] = 0; mOvf[k] = 0; mUnf[k] = 0;
            end else begin
                mTc[k] = 0;
                if (clr) begin
                    mCount[k] = 0; mOvf[k] = 0; mUnf[k] = 0;
                end else if (load) begin
                    mCount[k] = (int'(load_val) > maxv[k]) ? maxv[k] : int'(load_val);
                end else if (en && up) begin
                    if (mCount[k] == maxv[k]) begin
                        mTc[k] = 1; mOvf[k] = 1;
                        mCount[k] = sat ? maxv[k] : 0;
                    end else begin
                        mCount[k] = mCount[k] + 1;
                    end
                end else if (en) begin
                    if (mCount[k] == 0) begin
                        mTc[k] = 1; mUnf[k] = 1;
                        mCount[k] = sat ? 0 : maxv[k];
                    end else begin
                        mCount[k] = mCount[k] - 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("A.count", int'(countA), mCount[0]);
            checkOutput("A.tc",    int'(tcA),    int'(mTc[0]));
            checkOutput("A.ovf",   int'(ovfA),   int'(mOvf[0]));
            checkOutput("A.unf",   int'(unfA),   int'(mUnf[0]));
            checkOutput("B.count", int'(countB), mCount[1]);
            checkOutput("B.tc",    int'(tcB),    int'(mTc[1]));
            checkOutput("B.ovf",   int'(ovfB),   int'(mOvf[1]));
            checkOutput("B.unf",   int'(unfB),   int'(mUnf[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit e, input bit u, input bit s,
                                 input bit l, input logic [3:0] lv, input bit c);
        en = e; up = u; sat = s; load = l; load_val = lv; clr = c;
    endtask

    int seqUp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int seqDn[4]  = '{1, 0, 0, 0};

    initial begin
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 4'd0, 0);
        tick();
        tick();
        checking = 1'b1;
        checkOutput("reset.count", int'(countA), 0);
        checkOutput("reset.flags", int'({tcA, ovfA, unfA}), 0);

        rst = 1'b1;
        applyStimulus(1, 1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("wrapUp.count", int'(countA), seqUp[i]);
            checkOutput("wrapUp.tc", int'(tcA), (i == 9) ? 1 : 0);
            if (i >= 9) checkOutput("wrapUp.ovf", int'(ovfA), 1);
        end

        applyStimulus(1, 0, 1, 0, 4'd0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("satDown.count", int'(countA), seqDn[i]);
            checkOutput("satDown.tc", int'(tcA), (i >= 2) ? 1 : 0);
        end
        checkOutput("satDown.unf", int'(unfA), 1);

        applyStimulus(0, 0, 0, 1, 4'd15, 0);
        tick();
        checkOutput("loadClamp.count", int'(countA), 9);
        checkOutput("loadClamp.tc", int'(tcA), 0);
        checkOutput("loadB.count", int'(countB), 15);
        applyStimulus(1, 1, 0, 0, 4'd0, 0);
        tick();
        checkOutput("loadWrap.count", int'(countA), 0);
        checkOutput("loadWrap.tc", int'(tcA), 1);

        applyStimulus(1, 1, 0, 1, 4'd5, 1);
        tick();
        checkOutput("clrPrio.count", int'(countA), 0);
        checkOutput("clrPrio.flags", int'({ovfA, unfA}), 0);

        applyStimulus(0, 0, 0, 1, 4'd7, 0);
        tick();
        checkOutput("preRst.count", int'(countA), 7);
        applyStimulus(0, 1, 0, 0, 4'd0, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncRst.count", int'(countA), 0);
        checkOutput("asyncRst.flags", int'({tcA, ovfA, unfA}), 0);
        #3 rst = 1'b1;
        applyStimulus(1, 1, 0, 0, 4'd0, 0);
        tick();
        checkOutput("resume.count", int'(countA), 1);

        applyStimulus(0, 0, 0, 0, 4'd0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, (i % 2 == 0), 0, 0, 4'd0, 0);
            tick();
            checkOutput("toggle.count", int'(countB), (i % 2 == 0) ? 1 : 0);
            checkOutput("toggle.tc", int'(tcB), 0);
        end

        applyStimulus(0, 0, 0, 0, 4'd0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1, giving the terminal count (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter RST_VAL, default 0, giving the count value on reset and on clear (legal range 0..MAX_VAL).
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes occur on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-008 The block SHALL have port sat, input, 1 bit: boundary mode; 0 wraps, 1 saturates.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 The block SHALL have port clr, input, 1 bit: synchronous clear to RST_VAL, which also clears the sticky flags.
REQ-012 The block SHALL have port count, output, WIDTH bits: current count, registered.
REQ-013 The block SHALL have port tc, output, 1 bit: registered one-cycle boundary-event pulse.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky up-boundary flag.
REQ-015 The block SHALL have port unf, output, 1 bit: sticky down-boundary flag.

Function
REQ-016 The block SHALL apply per-cycle priority clr > load > en; with none of them asserted, all state SHALL hold.
REQ-017 The block SHALL, on clr, set count=RST_VAL, ovf=0, unf=0 and tc=0 at the next edge.
REQ-018 The block SHALL, on load, set count=load_val, clamping to MAX_VAL when load_val>MAX_VAL, leave ovf/unf unchanged, and drive tc=0.
REQ-019 The block SHALL, on en with up=1 and count<MAX_VAL, increment count by 1; with up=0 and count>0, it SHALL decrement count by 1.
REQ-020 The block SHALL, on en with up=1 and count==MAX_VAL, set count to 0 in wrap mode or hold count at MAX_VAL in saturate mode, and in both modes set tc=1 and ovf=1 at the same edge.
REQ-021 The block SHALL, on en with up=0 and count==0, set count to MAX_VAL in wrap mode or hold count at 0 in saturate mode, and in both modes set tc=1 and unf=1 at the same edge.
REQ-022 The block SHALL drive tc high for exactly one cycle per boundary event; consecutive boundary events (saturate with en held) SHALL hold tc high on each such cycle.
REQ-023 The block SHALL keep ovf and unf at 1 once set, until clr or reset.
REQ-024 The block SHALL allow up and sat to change on any cycle, with each taking effect at the next edge with no pipeline latency.
REQ-025 The block SHALL perform arithmetic at WIDTH+1 bits internally so that no intermediate overflow is visible, with count never exceeding MAX_VAL.
REQ-026 The block SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-027 The block SHALL, while rst=0, immediately and asynchronously force count=RST_VAL, tc=0, ovf=0 and unf=0, regardless of clk.
REQ-028 The block SHALL, on rst assertion mid-count, discard the in-progress state, and SHALL resume counting from RST_VAL at the first rising clk edge after rst deasserts.

Structure
REQ-029 The shared counter package SHALL hold the mode constants MODE_WRAP=0 and MODE_SAT=1 and a function computing the default MAX_VAL from WIDTH.
REQ-030 The block SHALL contain one sub-module, cnt_next_calc: a combinational next-count/boundary-detect unit taking count, up, sat and MAX_VAL and returning next count and the boundary-event flag.
REQ-031 The block SHALL elaborate-time check parameter legality, failing elaboration when MAX_VAL or RST_VAL is out of range.

Verification
REQ-032 The bench SHALL check, with WIDTH=4, MAX_VAL=9, sat=0, up=1 and en held from reset for 12 cycles, that count runs 1..9,0,1,2, with tc high only in the cycle where count shows 0, and ovf=1 thereafter.
REQ-033 The bench SHALL check, with WIDTH=4, MAX_VAL=9, sat=1, up=0 from count=2 and en held for 4 cycles, that count runs 1,0,0,0, with tc high on the last two cycles and unf=1.
REQ-034 The bench SHALL check that load=1 with load_val=15 under MAX_VAL=9 gives count=9 and tc=0, and that a following en, up=1, sat=0 gives count=0 and tc=1.
REQ-035 The bench SHALL check that clr, load and en asserted together give count=RST_VAL with ovf and unf cleared.
REQ-036 The bench SHALL check that rst pulsed low between clk edges while count=7 gives count=0 immediately and all flags 0, with counting resuming at 1 on the first edge after release.
REQ-037 The bench SHALL check, with default parameters (WIDTH=4, MAX_VAL=15), that up/down toggled every cycle from 0 gives count 1,0,1,0 and no tc.
